game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer. Replaces the constant-tied start/over/restart/success
//  stubs feeding state_fsm. Detects Mario/barrel and Mario/queue overlap, counts
//  lives and the bonus timer, and drives the 2-bit game state that mario, kong,
//  queue, barrel and the VGA mux decode.
//  All game-time actions advance only on the per-frame tick pulse.
// PARAMETERS
//  LIVES_INIT      3      lives loaded on game start (1..3)
//  BONUS_INIT      5000   bonus value loaded on start
//  BONUS_STEP      100    amount subtracted per bonus period
//  BONUS_PERIOD    60     ticks per bonus decrement
//  FREEZE_TICKS    90     freeze length after a non-fatal hit
//  END_TICKS       180    hold time in GAME_OVER / GAME_SUCCESS
//  MARIO_W/H       34/36  Mario box; the position is its top-left corner
//  BARREL_W/H      32/24  barrel box; the position is its top-left corner
//  QUEUE_W/H       44/50  queue box; the position is its centre
// PORTS
//  clk          in   1   system clock
//  rst          in   1   async active-high reset
//  tick         in   1   one-clk pulse per game frame
//  start_key    in   1   level; start request from key2state
//  mario_x      in   10  Mario top-left x
//  mario_y      in   9   Mario top-left y
//  barrel_x     in   10  barrel top-left x
//  barrel_y     in   9   barrel top-left y
//  barrel_act   in   1   barrel on screen; 0 masks barrel collision
//  queue_x      in   10  queue centre x
//  queue_y      in   9   queue centre y
//  state        out  2   00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
//  freeze       out  1   1 = objects hold position (hit freeze)
//  restart      out  1   one-clk pulse: sprites reload start positions
//  lives        out  2   remaining lives
//  bonus        out  16  bonus counter, unsigned
// BEHAVIOUR
//  Reset values: state=INITIAL, freeze=0, restart=0, lives=LIVES_INIT, bonus=0.
//    Internal counters are cleared to 0.
//  Start edge: start_key is registered once; start_rise = start_key & ~prev.
//  Collision test is combinational and strict:
//    ax < bx+bw  &&  bx < ax+aw  (same form for y).
//    Queue box corner = centre - W/2, H/2.
//    All sums are 11-bit to avoid wrap; touching edges are not a hit.
//  INITIAL:
//    On start_rise -> RUNNING, lives=LIVES_INIT, bonus=BONUS_INIT.
//    The restart pulse is issued in the same cycle.
//  RUNNING, evaluated only in a cycle with tick=1 and freeze=0. Priority:
//    1. queue hit -> SUCCESS. Success beats a simultaneous barrel hit.
//    2. barrel hit (barrel_act=1), or bonus==0:
//       - lives==1 -> lives=0, -> OVER.
//       - otherwise lives-1, freeze=1, freeze counter=0.
//    3. else bonus period counter +1. At BONUS_PERIOD-1, wrap to 0 and
//       bonus -= BONUS_STEP, saturating at 0 (never wraps).
//  Freeze:
//    Counter advances on tick. After FREEZE_TICKS ticks: freeze=0,
//    restart pulses once, bonus is reloaded to BONUS_INIT.
//    Collisions are ignored while frozen.
//  OVER / SUCCESS:
//    End counter advances on tick; start_key is ignored.
//    After END_TICKS ticks -> INITIAL with one restart pulse.
//  Outputs are registered; a state change appears 1 clk after the qualifying tick.
//  Async rst mid-game returns everything to reset values immediately; no restart pulse.
// STRUCTURE
//  game_pkg.vh: state codes GAME_INITIAL..GAME_SUCCESS and sprite size constants,
//    shared with top and the sprite modules.
//  Sub-module box_overlap (pure combinational), instantiated twice:
//    Mario/barrel and Mario/queue.
//  One state register plus freeze, bonus-period, freeze and end counters.
// TESTING
//  1. Reset, then start_key 0->1 -> restart pulse; state=01, lives=3, bonus=5000.
//  2. Mario (100,100), barrel (133,135), tick -> hit. lives=2, freeze=1.
//     After 90 ticks: freeze=0 plus one restart pulse.
//     Barrel (134,100) -> no hit (edge touch).
//  3. Three hits, each after the freeze clears -> state=10. After 180 ticks -> 00.
//     start_key held during OVER has no effect.
//  4. Mario (300,40), queue (320,60), barrel overlapping on the same tick
//     -> state=11, lives unchanged.
//  5. No collisions, 3000 ticks -> bonus 0 -> hit path. bonus never exceeds 5000
//     or wraps below 0.
//  6. rst asserted during freeze -> next clk state=00, freeze=0, lives=3, no restart.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game sequencer: state codes, bus widths,
// sprite box sizes and the saturating bonus decrement.
package game_ctrl_pkg;

    localparam int unsigned X_W     = 10;   // screen x coordinate width
    localparam int unsigned Y_W     = 9;    // screen y coordinate width
    localparam int unsigned COORD_W = 11;   // widened so box sums cannot wrap
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned BONUS_W = 16;

    localparam int unsigned MARIO_W  = 34;
    localparam int unsigned MARIO_H  = 36;
    localparam int unsigned BARREL_W = 32;
    localparam int unsigned BARREL_H = 24;
    localparam int unsigned QUEUE_W  = 44;
    localparam int unsigned QUEUE_H  = 50;

    typedef enum logic [1:0] {
        GAME_INITIAL = 2'b00,
        GAME_RUNNING = 2'b01,
        GAME_OVER    = 2'b10,
        GAME_SUCCESS = 2'b11
    } game_state_e;

    // Bonus decrement that clamps at zero instead of wrapping.
    function automatic logic [BONUS_W-1:0] bonus_dec(input logic [BONUS_W-1:0] bonus,
                                                     input logic [BONUS_W-1:0] step);
        return (bonus >= step) ? (bonus - step) : '0;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Game sequencer bus: frame tick, start key, sprite positions in;
// game state, freeze, restart pulse, lives and bonus out.
// master: the driving side (sprites/keys); slave: game_ctrl.
interface game_ctrl_if;
    import game_ctrl_pkg::*;

    logic               tick;
    logic               start_key;
    logic [X_W-1:0]     mario_x;
    logic [Y_W-1:0]     mario_y;
    logic [X_W-1:0]     barrel_x;
    logic [Y_W-1:0]     barrel_y;
    logic               barrel_act;
    logic [X_W-1:0]     queue_x;
    logic [Y_W-1:0]     queue_y;

    game_state_e        state;
    logic               freeze;
    logic               restart;
    logic [LIVES_W-1:0] lives;
    logic [BONUS_W-1:0] bonus;

    modport master (
        output tick, start_key, mario_x, mario_y, barrel_x, barrel_y,
               barrel_act, queue_x, queue_y,
        input  state, freeze, restart, lives, bonus
    );

    modport slave (
        input  tick, start_key, mario_x, mario_y, barrel_x, barrel_y,
               barrel_act, queue_x, queue_y,
        output state, freeze, restart, lives, bonus
    );

endinterface

// File: rtl/game_ctrl_box_overlap.sv
// Strict axis-aligned box overlap test; boxes given by top-left corner.
// Touching edges do not count as overlap.
// Ports: a_x_i/a_y_i, b_x_i/b_y_i corners in; overlap_c_o combinational out.
module game_ctrl_box_overlap
    import game_ctrl_pkg::*;
#(
    parameter int unsigned A_W = MARIO_W,
    parameter int unsigned A_H = MARIO_H,
    parameter int unsigned B_W = BARREL_W,
    parameter int unsigned B_H = BARREL_H
) (
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic               overlap_c_o
);

    logic [COORD_W-1:0] a_x_end;
    logic [COORD_W-1:0] a_y_end;
    logic [COORD_W-1:0] b_x_end;
    logic [COORD_W-1:0] b_y_end;

    always_comb begin
        a_x_end     = a_x_i + COORD_W'(A_W);
        a_y_end     = a_y_i + COORD_W'(A_H);
        b_x_end     = b_x_i + COORD_W'(B_W);
        b_y_end     = b_y_i + COORD_W'(B_H);
        overlap_c_o = (a_x_i < b_x_end) && (b_x_i < a_x_end) &&
                      (a_y_i < b_y_end) && (b_y_i < a_y_end);
    end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: start handling, Mario/barrel and Mario/queue
// collisions, lives, bonus timer, hit freeze and end-of-game hold.
// Ports: clk, rst (async active-high); bus_if (slave) carries tick,
// start_key, sprite positions in and state/freeze/restart/lives/bonus out.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned BONUS_INIT   = 5000,
    parameter int unsigned BONUS_STEP   = 100,
    parameter int unsigned BONUS_PERIOD = 60,
    parameter int unsigned FREEZE_TICKS = 90,
    parameter int unsigned END_TICKS    = 180
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus_if
);

    localparam int unsigned PER_W = $clog2(BONUS_PERIOD);
    localparam int unsigned FRZ_W = $clog2(FREEZE_TICKS);
    localparam int unsigned END_W = $clog2(END_TICKS);

    game_state_e        state_q,   state_d;
    logic               freeze_q,  freeze_d;
    logic               restart_q, restart_d;
    logic [LIVES_W-1:0] lives_q,   lives_d;
    logic [BONUS_W-1:0] bonus_q,   bonus_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [FRZ_W-1:0]   frz_cnt_q, frz_cnt_d;
    logic [END_W-1:0]   end_cnt_q, end_cnt_d;
    logic               start_prev_q;

    logic               start_rise;
    logic               barrel_ovl;
    logic               queue_ovl;
    logic               barrel_hit;

    assign start_rise = bus_if.start_key & ~start_prev_q;
    assign barrel_hit = barrel_ovl & bus_if.barrel_act;

    // Mario vs barrel
    game_ctrl_box_overlap #(
        .A_W(MARIO_W), .A_H(MARIO_H), .B_W(BARREL_W), .B_H(BARREL_H)
    ) u_barrel_ovl (
        .a_x_i       (COORD_W'(bus_if.mario_x)),
        .a_y_i       (COORD_W'(bus_if.mario_y)),
        .b_x_i       (COORD_W'(bus_if.barrel_x)),
        .b_y_i       (COORD_W'(bus_if.barrel_y)),
        .overlap_c_o (barrel_ovl)
    );

    // Mario vs queue; queue position is its centre, so shift to the corner
    game_ctrl_box_overlap #(
        .A_W(MARIO_W), .A_H(MARIO_H), .B_W(QUEUE_W), .B_H(QUEUE_H)
    ) u_queue_ovl (
        .a_x_i       (COORD_W'(bus_if.mario_x)),
        .a_y_i       (COORD_W'(bus_if.mario_y)),
        .b_x_i       (COORD_W'(bus_if.queue_x) - COORD_W'(QUEUE_W / 2)),
        .b_y_i       (COORD_W'(bus_if.queue_y) - COORD_W'(QUEUE_H / 2)),
        .overlap_c_o (queue_ovl)
    );

    // State register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= GAME_INITIAL;
            freeze_q     <= 1'b0;
            restart_q    <= 1'b0;
            lives_q      <= LIVES_W'(LIVES_INIT);
            bonus_q      <= '0;
            per_cnt_q    <= '0;
            frz_cnt_q    <= '0;
            end_cnt_q    <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            freeze_q     <= freeze_d;
            restart_q    <= restart_d;
            lives_q      <= lives_d;
            bonus_q      <= bonus_d;
            per_cnt_q    <= per_cnt_d;
            frz_cnt_q    <= frz_cnt_d;
            end_cnt_q    <= end_cnt_d;
            start_prev_q <= bus_if.start_key;
        end
    end

    // Next-state logic; game-time actions only on tick
    always_comb begin
        state_d   = state_q;
        freeze_d  = freeze_q;
        restart_d = 1'b0;
        lives_d   = lives_q;
        bonus_d   = bonus_q;
        per_cnt_d = per_cnt_q;
        frz_cnt_d = frz_cnt_q;
        end_cnt_d = end_cnt_q;

        unique case (state_q)
            GAME_INITIAL: begin
                if (start_rise) begin
                    state_d   = GAME_RUNNING;
                    lives_d   = LIVES_W'(LIVES_INIT);
                    bonus_d   = BONUS_W'(BONUS_INIT);
                    restart_d = 1'b1;
                    freeze_d  = 1'b0;
                    per_cnt_d = '0;
                    frz_cnt_d = '0;
                    end_cnt_d = '0;
                end
            end

            GAME_RUNNING: begin
                if (bus_if.tick) begin
                    if (freeze_q) begin
                        // Collisions are ignored until the freeze expires
                        if (frz_cnt_q == FRZ_W'(FREEZE_TICKS - 1)) begin
                            freeze_d  = 1'b0;
                            restart_d = 1'b1;
                            bonus_d   = BONUS_W'(BONUS_INIT);
                            frz_cnt_d = '0;
                        end else begin
                            frz_cnt_d = frz_cnt_q + FRZ_W'(1);
                        end
                    end else if (queue_ovl) begin
                        state_d   = GAME_SUCCESS;
                        end_cnt_d = '0;
                    end else if (barrel_hit || (bonus_q == '0)) begin
                        if (lives_q == LIVES_W'(1)) begin
                            lives_d   = '0;
                            state_d   = GAME_OVER;
                            end_cnt_d = '0;
                        end else begin
                            lives_d   = lives_q - LIVES_W'(1);
                            freeze_d  = 1'b1;
                            frz_cnt_d = '0;
                        end
                    end else if (per_cnt_q == PER_W'(BONUS_PERIOD - 1)) begin
                        per_cnt_d = '0;
                        bonus_d   = bonus_dec(bonus_q, BONUS_W'(BONUS_STEP));
                    end else begin
                        per_cnt_d = per_cnt_q + PER_W'(1);
                    end
                end
            end

            GAME_OVER, GAME_SUCCESS: begin
                if (bus_if.tick) begin
                    if (end_cnt_q == END_W'(END_TICKS - 1)) begin
                        state_d   = GAME_INITIAL;
                        restart_d = 1'b1;
                        end_cnt_d = '0;
                    end else begin
                        end_cnt_d = end_cnt_q + END_W'(1);
                    end
                end
            end
        endcase
    end

    assign bus_if.state   = state_q;
    assign bus_if.freeze  = freeze_q;
    assign bus_if.restart = restart_q;
    assign bus_if.lives   = lives_q;
    assign bus_if.bonus   = bonus_q;

endmodule
